// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO owner with single-cycle multiply, move-to-HI/LO and a stalling restoring divider
module hilo_mdu #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alucontrol,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_MTHI  = 8'b00010001;
  localparam logic [7:0] OP_MTLO  = 8'b00010011;
  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_count;
  logic [31:0] r_q, r_rem, r_dvs;
  logic r_qneg, r_rneg;
  logic w_go, w_sdiv, w_div, w_start, w_last, w_ge;
  logic [31:0] w_abs_a, w_abs_b, w_sub, w_q_nx, w_rem_nx;
  logic [32:0] w_sh;
  logic [63:0] w_smul, w_umul;
  assign w_go     = r_state == IDLE && valid && !flush;
  assign w_sdiv   = alucontrol == OP_DIV;
  assign w_div    = w_sdiv || alucontrol == OP_DIVU;
  assign w_start  = w_go && w_div && b != '0;
  assign w_last   = r_count == LAST;
  assign w_abs_a  = w_sdiv && a[31] ? -a : a;
  assign w_abs_b  = w_sdiv && b[31] ? -b : b;
  assign w_smul   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_umul   = {32'b0, a} * {32'b0, b};
  assign w_sh     = {r_rem, r_q[31]};
  assign w_ge     = w_sh >= {1'b0, r_dvs};
  assign w_sub    = w_sh[31:0] - r_dvs;
  assign w_rem_nx = w_ge ? w_sub : w_sh[31:0];
  assign w_q_nx   = {r_q[30:0], w_ge};
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state; flush wins over completion, stall held off during reset
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    done   = 1'b0;
    w_next = r_state == IDLE ? (w_start ? DIV_RUN : IDLE) :
             r_state == DIV_RUN ? (flush ? IDLE : w_last ? DONE : DIV_RUN) : IDLE;
    stall  = !rst && (w_start || (r_state == DIV_RUN && !flush));
    done   = r_state == DONE;
  end
  // HI/LO updates and divider datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else if (w_go) begin
      if (alucontrol == OP_MULT) {hi, lo} <= w_smul;
      else if (alucontrol == OP_MULTU) {hi, lo} <= w_umul;
      else if (alucontrol == OP_MTHI) hi <= a;
      else if (alucontrol == OP_MTLO) lo <= a;
      else if (w_div && b == '0) begin
        hi <= a;
        lo <= '1;
      end else if (w_div) begin
        r_q     <= w_abs_a;
        r_dvs   <= w_abs_b;
        r_rem   <= '0;
        r_count <= '0;
        r_qneg  <= w_sdiv && (a[31] ^ b[31]);
        r_rneg  <= w_sdiv && a[31];
      end
    end else if (r_state == DIV_RUN && !flush) begin
      r_q     <= w_q_nx;
      r_rem   <= w_rem_nx;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        lo <= r_qneg ? -w_q_nx : w_q_nx;
        hi <= r_rneg ? -w_rem_nx : w_rem_nx;
      end
    end
  end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: scoreboard bench for hilo_mdu against an arithmetic HI/LO model
module tb_hilo_mdu;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_MTHI  = 8'b00010001;
  localparam logic [7:0] OP_MTLO  = 8'b00010011;
  typedef struct {logic [31:0] h; logic [31:0] l; bit dv;} exp_t;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, flush = 1'b0;
  logic [7:0] alucontrol = '0;
  logic [31:0] a = '0, b = '0;
  logic stall, done;
  logic [31:0] hi, lo;
  logic [31:0] m_hi = '0, m_lo = '0;
  exp_t q[$];
  bit imm_chk = 1'b0;
  int done_cnt = 0, run = 0, n_pass = 0, n_tot = 0;
  logic [7:0] ops [7];

  hilo_mdu dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .valid(valid), .flush(flush),
    .a(a), .b(b), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference: plain 64-bit arithmetic, returns 1 when the op is a stalling divide
  function automatic bit model(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    model = 1'b0;
    if (op == OP_MULT) begin
      p = 64'(sx * sy);
      {m_hi, m_lo} = p;
    end else if (op == OP_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
      {m_hi, m_lo} = p;
    end else if (op == OP_MTHI) m_hi = x;
    else if (op == OP_MTLO) m_lo = x;
    else if ((op == OP_DIV || op == OP_DIVU) && y == 0) begin
      m_hi = x;
      m_lo = 32'hFFFF_FFFF;
    end else if (op == OP_DIV) begin
      m_lo = 32'(sx / sy);
      m_hi = 32'(sx % sy);
      model = 1'b1;
    end else if (op == OP_DIVU) begin
      m_lo = x / y;
      m_hi = x % y;
      model = 1'b1;
    end
  endfunction

  task automatic scramble(input bit live);
    valid = live ? 1'($urandom) : 1'b0;
    alucontrol = ops[$urandom_range(6, 0)];
    a = $urandom;
    b = $urandom;
    flush = 1'b0;
  endtask

  // drive one op starting at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle
  task automatic issue(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    bit dv;
    int n, d0;
    alucontrol = op; a = x; b = y; valid = 1'b1; flush = 1'b0;
    dv = model(op, x, y);
    e.h = m_hi; e.l = m_lo; e.dv = dv;
    q.push_back(e);
    @(negedge clk);
    chk("stall_at_issue", 64'(stall), 64'(dv));
    @(posedge clk); #1;
    scramble(1'b0);
    if (!dv) imm_chk = 1'b1;
    else begin
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 50) begin
        scramble(1'b1);
        @(posedge clk); #1;
        n++;
      end
      valid = 1'b0;
      if (done_cnt == d0) begin
        chk("div_timeout", 64'd1, 64'd0);
        rst = 1'b1; #1; rst = 1'b0;
        m_hi = '0; m_lo = '0;
        q.delete();
      end
    end
  endtask

  // start DIVU 9/4 over a preloaded HI/LO and kill it at iteration 10 by flush or reset
  task automatic abort_div(input bit use_rst);
    int d0;
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    issue(OP_MTLO, 32'h1234_5678, 32'h0);
    d0 = done_cnt;
    alucontrol = OP_DIVU; a = 32'd9; b = 32'd4; valid = 1'b1;
    @(posedge clk); #1;
    scramble(1'b0);
    repeat (9) begin @(posedge clk); #1; end
    if (use_rst) begin
      rst = 1'b1;
      alucontrol = OP_DIVU; a = 32'd9; b = 32'd4; valid = 1'b1;
      m_hi = '0; m_lo = '0;
    end else flush = 1'b1;
    @(negedge clk);
    chk(use_rst ? "stall_in_rst" : "stall_in_flush", 64'(stall), 64'd0);
    if (use_rst) chk("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("abort_idle_stall", 64'(stall), 64'd0);
    chk("abort_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    chk("abort_hilo_late", {hi, lo}, {m_hi, m_lo});
  endtask

  // monitor: divide results on done, single-cycle results one cycle after issue, stall run length
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("div_stall_cycles", 64'(run), 64'd33);
        if (q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("done_is_div", 64'(e.dv), 64'd1);
          chk("div_hi", 64'(hi), 64'(e.h));
          chk("div_lo", 64'(lo), 64'(e.l));
        end
      end
      if (imm_chk) begin
        imm_chk = 1'b0;
        if (q.size() == 0) chk("imm_missing", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("imm_hi", 64'(hi), 64'(e.h));
          chk("imm_lo", 64'(lo), 64'(e.l));
        end
      end
      run = stall ? run + 1 : 0;
    end
  end

  initial begin
    logic [7:0] op;
    logic [31:0] x, y;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, 8'h2A};
    alucontrol = OP_DIV; a = 32'd7; b = 32'd2; valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(OP_DIVU, 32'd100, 32'd0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'd100, 32'd0);
    issue(8'h2A, 32'hDEAD_BEEF, 32'h1);
    alucontrol = OP_MULT; a = 32'd3; b = 32'd5; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    alucontrol = OP_MTHI; a = 32'h5555_AAAA; valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_hilo", {hi, lo}, {m_hi, m_lo});
    @(posedge clk); #1;
    @(negedge clk);
    chk("novalid_hilo", {hi, lo}, {m_hi, m_lo});
    @(posedge clk); #1;
    abort_div(1'b0);
    abort_div(1'b1);
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(6, 0)];
      x = $urandom;
      y = $urandom;
      case ($urandom_range(9, 0))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(15, 1);
        default: ;
      endcase
      issue(op, x, y);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
